jtag_1149_d10_mstr_rx_link_mgr: RTL

Parametrised successor to the Master Rx controller's retry, timeout and flow-control logic. It tracks each transmitted PEDDA packet through a response state machine and applies these runtime-programmable limits: retry budget, response timeout and XOFF watchdog. It also keeps saturating error statistics. It sits between the Rx packet, error and flow-control detectors and the Rx-to-Tx control interface.

---
 rtl/jtag_1149_d10_mstr_rx_link_mgr.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_1149_d10_mstr_rx_link_mgr.sv
// Master Rx link manager: follows each launched PEDDA packet through its
// response, decides on retry / fail / timeout, runs the XOFF watchdog and
// keeps saturating error statistics for the Rx-to-Tx control interface.
module jtag_1149_d10_mstr_rx_link_mgr #(
  parameter int RETRY_WIDTH    = 3,
  parameter int TOUT_WIDTH     = 16,
  parameter int ERR_CNTR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RETRY_WIDTH-1:0]    cfg_max_retry,
  input  logic [TOUT_WIDTH-1:0]     cfg_rsp_tout,
  input  logic [TOUT_WIDTH-1:0]     cfg_xoff_tout,
  input  logic                      cfg_tout_retry_en,
  input  logic                      sts_clr,
  input  logic                      send_pkt,
  input  logic                      sop_detected,
  input  logic                      rd_nxt_instr,
  input  logic                      error_char_detected,
  input  logic                      crc_error_detected,
  input  logic                      xoff_detected,
  input  logic                      xon_detected,
  output logic                      instr_retry,
  output logic [RETRY_WIDTH-1:0]    retry_cnt,
  output logic                      unrecoverable_error,
  output logic                      scan_rsp_time_out,
  output logic                      suspend_xmission,
  output logic                      xoff_time_out,
  output logic                      busy,
  output logic [ERR_CNTR_WIDTH-1:0] crc_err_cnt,
  output logic [ERR_CNTR_WIDTH-1:0] err_char_cnt,
  output logic [ERR_CNTR_WIDTH-1:0] tout_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_RSP = 3'd1;
  localparam logic [2:0] ST_RX_PKT   = 3'd2;
  localparam logic [2:0] ST_RETRY    = 3'd3;
  localparam logic [2:0] ST_FAIL     = 3'd4;

  localparam logic [TOUT_WIDTH-1:0]     T_ONE = {{(TOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RETRY_WIDTH-1:0]    R_ONE = {{(RETRY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNTR_WIDTH-1:0] C_ONE = {{(ERR_CNTR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]             state, state_nxt;
  logic [TOUT_WIDTH-1:0]  rsp_timer, rsp_timer_nxt;
  logic [TOUT_WIDTH-1:0]  xoff_timer;
  logic [RETRY_WIDTH-1:0] retry_cnt_nxt;
  logic                   err_evt;
  logic                   rsp_frozen;
  logic                   rsp_tout_hit;
  logic                   take_err;
  logic                   tout_fire;
  logic                   retry_fire;
  logic                   xoff_fire;

  assign err_evt    = error_char_detected | crc_error_detected;
  // The response timer stands still while Tx is held off by XOFF.
  assign rsp_frozen = suspend_xmission;
  assign rsp_tout_hit = (cfg_rsp_tout != '0) && !rsp_frozen &&
                        (rsp_timer == cfg_rsp_tout - T_ONE);

  // A fresh XOFF restarts the watchdog instead of letting it expire.
  assign xoff_fire = (cfg_xoff_tout != '0) && suspend_xmission && !xoff_detected &&
                     (xoff_timer == cfg_xoff_tout - T_ONE);

  // Response state machine: next state, timer and retry budget.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt     = state;
    rsp_timer_nxt = rsp_timer;
    retry_cnt_nxt = retry_cnt;
    take_err      = 1'b0;
    tout_fire     = 1'b0;
    retry_fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        rsp_timer_nxt = '0;
        if (send_pkt) state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP, ST_RX_PKT: begin
        rsp_timer_nxt = rsp_frozen ? rsp_timer : rsp_timer + T_ONE;
        if (err_evt) begin
          take_err = 1'b1;
        end else if (state == ST_RX_PKT && rd_nxt_instr) begin
          state_nxt     = ST_IDLE;
          retry_cnt_nxt = '0;
          rsp_timer_nxt = '0;
        end else if (state == ST_WAIT_RSP && sop_detected) begin
          state_nxt     = ST_RX_PKT;
          rsp_timer_nxt = '0;
        end else if (rsp_tout_hit) begin
          tout_fire = 1'b1;
          if (cfg_tout_retry_en) begin
            take_err = 1'b1;
          end else begin
            state_nxt     = ST_IDLE;
            retry_cnt_nxt = '0;
            rsp_timer_nxt = '0;
          end
        end
        if (take_err) begin
          rsp_timer_nxt = '0;
          if (retry_cnt < cfg_max_retry) begin
            retry_fire    = 1'b1;
            retry_cnt_nxt = retry_cnt + R_ONE;
            state_nxt     = ST_RETRY;
          end else begin
            state_nxt = ST_FAIL;
          end
        end
      end
      ST_RETRY: begin
        rsp_timer_nxt = '0;
        if (send_pkt) state_nxt = ST_WAIT_RSP;
      end
      ST_FAIL: begin
        rsp_timer_nxt = '0;
        if (sts_clr) begin
          state_nxt     = ST_IDLE;
          retry_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        rsp_timer_nxt = '0;
      end
    endcase
  end

  // State, timer and registered FSM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      rsp_timer           <= '0;
      retry_cnt           <= '0;
      instr_retry         <= 1'b0;
      scan_rsp_time_out   <= 1'b0;
      busy                <= 1'b0;
      unrecoverable_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state               <= state_nxt;
      rsp_timer           <= rsp_timer_nxt;
      retry_cnt           <= retry_cnt_nxt;
      instr_retry         <= retry_fire;
      scan_rsp_time_out   <= tout_fire;
      busy                <= (state_nxt != ST_IDLE);
      unrecoverable_error <= (state_nxt == ST_FAIL);
    end
  end

  // Flow control: XOFF/XON tracking and the XOFF watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suspend_xmission <= 1'b0;
      xoff_timer       <= '0;
      xoff_time_out    <= 1'b0;
    end else begin
      xoff_time_out <= xoff_fire;
      if (xoff_detected)                   suspend_xmission <= 1'b1;
      else if (xoff_fire || xon_detected)  suspend_xmission <= 1'b0;
      if (suspend_xmission && !xoff_detected && !xoff_fire) xoff_timer <= xoff_timer + T_ONE;
      else                                                  xoff_timer <= '0;
    end
  end

  // Saturating statistics; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_cnt  <= '0;
      err_char_cnt <= '0;
      tout_cnt     <= '0;
    end else if (sts_clr) begin
      crc_err_cnt  <= '0;
      err_char_cnt <= '0;
      tout_cnt     <= '0;
    end else begin
      if (crc_error_detected && !(&crc_err_cnt))   crc_err_cnt  <= crc_err_cnt + C_ONE;
      if (error_char_detected && !(&err_char_cnt)) err_char_cnt <= err_char_cnt + C_ONE;
      if (tout_fire && !(&tout_cnt))               tout_cnt     <= tout_cnt + C_ONE;
    end
  end

endmodule
